// File: rtl/bitsel_pkg.sv
// bitsel_pkg: shared FSM type, defaults and helpers for the bit-select routing controller
package bitsel_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SWAP = 2'd2} state_t;
    function automatic int unsigned identity_sel(int unsigned i);
        return i;
    endfunction
endpackage

// File: rtl/bitsel_route_dp.sv
// bitsel_route_dp: combinational per-lane bit-select mux driven by a flattened select vector
module bitsel_route_dp
    import bitsel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SELW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]      in_data,
    input  logic [WIDTH*SELW-1:0] sel,
    output logic [WIDTH-1:0]      out_data
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [SELW-1:0] s;
        assign s = sel[i*SELW +: SELW];
        // out-of-range sources only exist for non-power-of-2 widths and read as 0
        assign out_data[i] = (int'(s) < WIDTH) ? in_data[s] : 1'b0;
    end
endmodule

// File: rtl/bitsel_route_ctrl.sv
// bitsel_route_ctrl: registered bit-select router with double-buffered selects and drain-before-swap commit
module bitsel_route_ctrl
    import bitsel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SELW = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SELW-1:0]  cfg_lane,
    input  logic [SELW-1:0]  cfg_src,
    input  logic             cfg_commit,
    output logic             commit_done,
    output logic             cfg_err,
    output logic             busy
);
    state_t state;
    logic [WIDTH*SELW-1:0] active, shadow, ident;
    logic [WIDTH-1:0] routed;
    logic accept, cfg_wr, cfg_legal;
    always_comb begin
        ident = '0;
        for (int i = 0; i < WIDTH; i++) ident[i*SELW +: SELW] = SELW'(identity_sel(i));
    end
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign cfg_ready = (state == RUN);
    assign busy      = (state != RUN);
    assign accept    = in_valid && in_ready;
    assign cfg_wr    = cfg_valid && cfg_ready;
    assign cfg_legal = (int'(cfg_lane) < WIDTH) && (int'(cfg_src) < WIDTH);
    bitsel_route_dp #(.WIDTH(WIDTH), .SELW(SELW)) u_dp (
        .in_data (in_data),
        .sel     (active),
        .out_data(routed)
    );
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state       <= RUN;
            active      <= ident;
            shadow      <= ident;
            out_valid   <= 1'b0;
            out_data    <= '0;
            commit_done <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            commit_done <= (state == SWAP);
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= routed;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cfg_wr && cfg_legal) shadow[cfg_lane*SELW +: SELW] <= cfg_src;
            if (cfg_wr && !cfg_legal) cfg_err <= 1'b1;
            // the swap only happens once the output register is empty or emptying
            case (state)
                RUN:     if (cfg_commit) state <= DRAIN;
                DRAIN:   if (!out_valid || out_ready) state <= SWAP;
                SWAP:    begin
                    active <= shadow;
                    state  <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_bitsel_route_ctrl.sv
// tb_bitsel_route_ctrl: randomized scoreboard bench for bitsel_route_ctrl against a lane-mapping model
module tb_bitsel_route_ctrl;
    localparam int W = 4;
    localparam int SW = 2;
    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [W-1:0] in_data = '0, out_data;
    logic cfg_valid = 1'b0, cfg_ready, cfg_commit = 1'b0, commit_done, cfg_err, busy;
    logic [SW-1:0] cfg_lane = '0, cfg_src = '0;
    logic t_in_valid = 1'b0, t_in_ready, t_out_valid, t_cfg_valid = 1'b0, t_cfg_ready;
    logic t_cfg_commit = 1'b0, t_commit_done, t_cfg_err, t_busy;
    logic [2:0] t_in_data = '0, t_out_data;
    logic [1:0] t_cfg_lane = '0, t_cfg_src = '0;
    int checks = 0, failures = 0;
    int act_m[W], sh_m[W];
    int m_state = 0;
    logic m_ov = 1'b0, m_cd = 1'b0;
    logic [W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    bitsel_route_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lane(cfg_lane), .cfg_src(cfg_src),
        .cfg_commit(cfg_commit), .commit_done(commit_done), .cfg_err(cfg_err), .busy(busy)
    );

    bitsel_route_ctrl #(.WIDTH(3)) dut3 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
        .out_valid(t_out_valid), .out_ready(1'b1), .out_data(t_out_data),
        .cfg_valid(t_cfg_valid), .cfg_ready(t_cfg_ready), .cfg_lane(t_cfg_lane), .cfg_src(t_cfg_src),
        .cfg_commit(t_cfg_commit), .commit_done(t_commit_done), .cfg_err(t_cfg_err), .busy(t_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] route(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[act_m[i]];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            act_m[i] = i;
            sh_m[i]  = i;
        end
        m_state = 0;
        m_ov    = 1'b0;
        m_cd    = 1'b0;
        exp_q.delete();
    endtask

    // one clock of stimulus; checks handshake outputs against the model, then advances it
    task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy,
                         input logic cv = 1'b0, input logic [SW-1:0] ln = '0,
                         input logic [SW-1:0] sr = '0, input logic cm = 1'b0);
        logic acc, exp_rdy;
        @(posedge CLK); #1;
        in_valid = v; in_data = d; out_ready = rdy;
        cfg_valid = cv; cfg_lane = ln; cfg_src = sr; cfg_commit = cm;
        #1;
        exp_rdy = (m_state == 0) && (!m_ov || rdy);
        acc = v && exp_rdy;
        check("in_ready", in_ready, exp_rdy);
        check("cfg_ready", cfg_ready, m_state == 0);
        check("busy", busy, m_state != 0);
        check("out_valid", out_valid, m_ov);
        check("commit_done", commit_done, m_cd);
        check("cfg_err", cfg_err, 1'b0);
        if (acc) exp_q.push_back(route(d));
        if (cv && m_state == 0) sh_m[ln] = sr;
        m_cd = (m_state == 2);
        if (m_state == 2) act_m = sh_m;
        m_state = (m_state == 0) ? (cm ? 1 : 0) : (m_state == 1) ? ((!m_ov || rdy) ? 2 : 1) : 0;
        m_ov = acc ? 1'b1 : (rdy ? 1'b0 : m_ov);
    endtask

    task automatic do_reset();
        #4;
        ASYNCRESETN = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_commit_done", commit_done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        model_reset();
        in_valid = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #3;
        ASYNCRESETN = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (ASYNCRESETN && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected: got %0h with no beat expected", out_data);
            end else begin
                check("beat", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset();
        drive(1'b1, 4'b1010, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("identity_out", out_data, 4'b1010);
        drive(1'b0, '0, 1'b1, 1'b1, 2'd0, 2'd0);
        drive(1'b0, '0, 1'b1, 1'b1, 2'd1, 2'd0);
        drive(1'b0, '0, 1'b1, 1'b1, 2'd2, 2'd1);
        drive(1'b0, '0, 1'b1, 1'b1, 2'd3, 2'd2);
        drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 4'b0110, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("remap_out", out_data, 4'b1100);
        drive(1'b1, 4'b0001, 1'b0);
        for (int i = 0; i < W; i++) drive(1'b0, '0, 1'b0, 1'b1, SW'(i), SW'(i));
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (4) drive(1'b1, 4'b1111, 1'b0);
        check("drain_hold", out_data, 4'b0011);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 4'b0001, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("post_drain_out", out_data, 4'b0001);
        drive(1'b0, '0, 1'b1, 1'b1, 2'd3, 2'd0);
        repeat (8) drive(1'b1, 4'($urandom), 1'b1);
        drive(1'b0, '0, 1'b1);
        repeat (300) drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 1) == 1, 2'($urandom), 2'($urandom), $urandom_range(0, 15) == 0);
        repeat (4) drive(1'b0, '0, 1'b1);
        drive(1'b1, 4'b0101, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 2'd0, 2'd3);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        do_reset();
        drive(1'b1, 4'b1000, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("reset_drain_identity", out_data, 4'b1000);
        drive(1'b0, '0, 1'b1, 1'b1, 2'd1, 2'd3);
        drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(posedge CLK); #1;
        check("swap_busy", busy, 1'b1);
        do_reset();
        drive(1'b1, 4'b0010, 1'b1);
        drive(1'b0, '0, 1'b1);
        check("reset_swap_identity", out_data, 4'b0010);
        @(posedge CLK); #1;
        t_cfg_valid = 1'b1; t_cfg_lane = 2'd3; t_cfg_src = 2'd0;
        @(posedge CLK); #1;
        check("w3_err_lane", t_cfg_err, 1'b1);
        t_cfg_lane = 2'd0; t_cfg_src = 2'd3;
        @(posedge CLK); #1;
        t_cfg_valid = 1'b0; t_cfg_commit = 1'b1;
        check("w3_err_sticky", t_cfg_err, 1'b1);
        @(posedge CLK); #1;
        t_cfg_commit = 1'b0;
        check("w3_busy", t_busy, 1'b1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("w3_commit_done", t_commit_done, 1'b1);
        t_in_valid = 1'b1; t_in_data = 3'b011;
        @(posedge CLK); #1;
        t_in_valid = 1'b0;
        check("w3_identity", t_out_data, 3'b011);
        check("w3_out_valid", t_out_valid, 1'b1);
        check("w3_err_final", t_cfg_err, 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
